e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  E-stage multiply/divide unit: the consumer of the HILO control and operands that the E pipeline register delivers.
//  Runs multi-cycle mult/multu/div/divu into HI/LO, performs mthi/mtlo, and supplies mfhi/mflo data.
//  Returns Start/Busy to the hazard unit, which stalls D while either is high.
//  Honours Req (exception flush): no new operation starts on a Req cycle.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high for mult/multu
//  DIV_CYCLES   10  cycles Busy stays high for div/divu
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  Req        in   1   exception/interrupt flush; blocks every write this cycle
//  HILOtype   in   4   operation code (encoding in constants.v, see STRUCTURE)
//  A          in   32  forwarded rs value
//  B          in   32  forwarded rt value
//  Start      out  1   combinational; high when a mult/div is accepted this cycle
//  Busy       out  1   registered; high while an operation is in flight
//  HI         out  32  architectural HI register
//  LO         out  32  architectural LO register
//  MDU_Result out  32  HI for mfhi, LO for mflo, else 0 (combinational)
// BEHAVIOUR
//  - Reset (async): HI=LO=0, Busy=0, counter=0, shadow registers=0. All outputs read 0 immediately.
//  - Start = (HILOtype in {MULT,MULTU,DIV,DIVU}) & ~Req & ~Busy.
//  - Accept cycle (Start=1):
//    - MULT/MULTU: 64-bit signed/unsigned A*B into shadow {hi,lo}.
//    - DIV/DIVU: lo=A/B, hi=A%B, signed or unsigned. Signed division truncates toward zero; remainder takes the sign of the dividend.
//    - Counter loads MULT_CYCLES or DIV_CYCLES. Busy rises next edge.
//  - In flight: counter decrements every cycle. HI/LO still hold their old values.
//    - When the counter reaches 1, the next edge writes shadow into HI/LO, clears Busy and zeroes the counter.
//    - Busy is high for exactly N cycles after the accept edge; HI/LO are readable on the cycle Busy falls.
//  - Divide by zero (B==0): op runs full DIV_CYCLES with Busy; HI/LO are left unchanged at completion.
//  - MTHI/MTLO: HI<=A / LO<=A at the next edge when ~Req & ~Busy; 1-cycle, no Busy.
//  - MFHI/MFLO: MDU_Result is combinational from the current HI/LO.
//  - Req mid-operation: the in-flight op is older than the faulting instruction, so it completes normally.
//    Req only suppresses new starts and mthi/mtlo on its cycle.
//  - Any HILO op while Busy (hazard unit should prevent this) is ignored; no state change.
//  - Reset mid-operation: everything clears at once. The pending result is discarded.
//  - Simultaneous completion edge and new HILOtype: Busy is still 1 on that cycle, so the new op is ignored.
//    The hazard unit holds it in D; it is accepted next cycle.
//  - Width: the signed product uses $signed on both 32-bit operands, 64-bit result. No overflow or exception from the MDU.
// STRUCTURE
//  - constants.v (shared): `HILO_NONE=0, `HILO_MULT=1, `HILO_MULTU=2, `HILO_DIV=3, `HILO_DIVU=4,
//    `HILO_MFHI=5, `HILO_MFLO=6, `HILO_MTHI=7, `HILO_MTLO=8.
//    The D-stage controller and the E register use the same encoding.
//  - One module, no sub-module: a counter sized $clog2(DIV_CYCLES+1), plus shadow_hi/shadow_lo, HI/LO and Busy flops.
//  - Arithmetic is behavioural (*, /, %). No iterative divider.
// TESTING
//  1. MULT A=-3 (FFFFFFFD), B=4 -> Start=1 cycle 0; Busy=1 cycles 1..5; HI=FFFFFFFF, LO=FFFFFFF4 from cycle 6.
//  2. DIV A=-7, B=2 -> after 10 Busy cycles LO=FFFFFFFD, HI=FFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
//  3. MULTU with Req=1 on the issue cycle -> Start=0, Busy never rises, HI/LO unchanged.
//     MTHI A=5 with Req=1 -> HI unchanged.
//  4. MULT in flight, Req pulsed at cycle 2 -> op still completes on schedule with the correct HI/LO.
//     MTLO A=9 issued while Busy -> LO is not 9.
//  5. DIV B=0 with HI=0x11, LO=0x22 -> Busy for 10 cycles, then HI=0x11, LO=0x22.
//     MFLO afterwards -> MDU_Result=0x22.
//  6. DIVU started, reset asserted mid-cycle 4 (async) -> Busy, HI and LO fall to 0 immediately.
//     A new MULT 2*3 after reset -> LO=6 after 5 Busy cycles.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared HILO operation encoding and helpers for the E-stage multiply/divide unit.
package e_mdu_pkg;

  localparam int HILO_W = 4;

  // Same encoding used by the D-stage controller and the E pipeline register.
  typedef enum logic [HILO_W-1:0] {
    HILO_NONE  = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MFHI  = 4'd5,
    HILO_MFLO  = 4'd6,
    HILO_MTHI  = 4'd7,
    HILO_MTLO  = 4'd8
  } hilo_op_e;

  // True for the multi-cycle operations that raise Busy.
  function automatic logic is_muldiv(input logic [HILO_W-1:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU) ||
           (op == HILO_DIV)  || (op == HILO_DIVU);
  endfunction

  // True for the two divide operations.
  function automatic logic is_div(input logic [HILO_W-1:0] op);
    return (op == HILO_DIV) || (op == HILO_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Results are computed behaviourally on the
// accept cycle into shadow registers, then committed to HI/LO after a fixed
// Busy window that mimics the latency of the real multiplier/divider.
//
// Handshake: Start is combinational and means "this HILOtype is accepted this
// cycle" (mul/div op present, no Req, not Busy). Busy is registered and stays
// high for exactly the op's cycle count after the accept edge; the hazard unit
// stalls D while Start or Busy is high. Anything presented while Busy is
// dropped without effect.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  HILOtype,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Result
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      shadow_hi_q, shadow_hi_d;
  logic [31:0]      shadow_lo_q, shadow_lo_d;

  logic [63:0]        mul_s, mul_u;
  logic signed [31:0] a_s, b_s;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;

  assign a_s = $signed(A);
  assign b_s = $signed(B);

  // Behavioural arithmetic; the divide-by-zero guard keeps the datapath defined.
  always_comb begin
    mul_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
    mul_u = {32'd0, A} * {32'd0, B};
    quo_s = 32'd0;
    rem_s = 32'd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (B != 32'd0) begin
      quo_s = a_s / b_s;
      rem_s = a_s % b_s;
      quo_u = A / B;
      rem_u = A % B;
    end
  end

  assign Start = is_muldiv(HILOtype) & ~Req & ~busy_q;

  // Next-state: accept a new op, count down an in-flight op, or handle mthi/mtlo.
  always_comb begin
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    dz_d        = dz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    if (Start) begin
      busy_d = 1'b1;
      dz_d   = is_div(HILOtype) && (B == 32'd0);
      cnt_d  = is_div(HILOtype) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      case (HILOtype)
        HILO_MULT:  {shadow_hi_d, shadow_lo_d} = mul_s;
        HILO_MULTU: {shadow_hi_d, shadow_lo_d} = mul_u;
        HILO_DIV:   {shadow_hi_d, shadow_lo_d} = {rem_s, quo_s};
        default:    {shadow_hi_d, shadow_lo_d} = {rem_u, quo_u};
      endcase
    end else if (busy_q) begin
      // The in-flight op is older than any faulting instruction, so Req is ignored here.
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        dz_d   = 1'b0;
        if (!dz_q) begin
          hi_d = shadow_hi_q;
          lo_d = shadow_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (!Req) begin
      if (HILOtype == HILO_MTHI) hi_d = A;
      if (HILOtype == HILO_MTLO) lo_d = A;
    end
  end

  // State registers with asynchronous clear; a reset discards any pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      dz_q        <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      shadow_hi_q <= 32'd0;
      shadow_lo_q <= 32'd0;
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      dz_q        <= dz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Move-from-HI/LO read port.
  always_comb begin
    MDU_Result = 32'd0;
    if (HILOtype == HILO_MFHI) MDU_Result = hi_q;
    if (HILOtype == HILO_MFLO) MDU_Result = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed vectors, checked with immediate assertions.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        Req;
  logic [3:0]  HILOtype;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_Result;

  int checks = 0;
  int errors = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .Req        (Req),
    .HILOtype   (HILOtype),
    .A          (A),
    .B          (B),
    .Start      (Start),
    .Busy       (Busy),
    .HI         (HI),
    .LO         (LO),
    .MDU_Result (MDU_Result)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a mul/div op, expect it accepted, then expect Busy for n cycles
  // and HI/LO to hold old_hi/old_lo throughout. Ends on the cycle Busy falls.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo);
    HILOtype = op; A = a; B = b;
    #1;
    check({tag, "_start"}, {31'd0, Start}, 32'd1);
    step();
    HILOtype = HILO_NONE;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s_busy_c%0d", tag, i), {31'd0, Busy}, 32'd1);
      check($sformatf("%s_hold_hi_c%0d", tag, i), HI, old_hi);
      check($sformatf("%s_hold_lo_c%0d", tag, i), LO, old_lo);
      step();
    end
    check({tag, "_busy_fall"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; HILOtype = HILO_NONE; A = 32'd0; B = 32'd0;
    #12;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", {31'd0, Start}, 32'd0);
    check("rst_result", MDU_Result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // 1. MULT -3 * 4
    run_op("mult", HILO_MULT, 32'hFFFFFFFD, 32'd4, 5, 32'd0, 32'd0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF4);

    // 2. DIV -7 / 2 and DIVU 7 / 2
    run_op("div", HILO_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFF4);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);
    run_op("divu", HILO_DIVU, 32'd7, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    // 3. Req blocks MULTU and MTHI
    HILOtype = HILO_MULTU; A = 32'd9; B = 32'd9; Req = 1'b1;
    #1;
    check("req_multu_start", {31'd0, Start}, 32'd0);
    step();
    HILOtype = HILO_NONE; Req = 1'b0;
    check("req_multu_busy", {31'd0, Busy}, 32'd0);
    step();
    check("req_multu_busy2", {31'd0, Busy}, 32'd0);
    check("req_multu_hi", HI, 32'd1);
    check("req_multu_lo", LO, 32'd3);
    HILOtype = HILO_MTHI; A = 32'd5; Req = 1'b1;
    step();
    HILOtype = HILO_NONE; Req = 1'b0;
    check("req_mthi_hi", HI, 32'd1);

    // 4. MULT 6*7 with Req pulsed mid-flight, MTLO while Busy ignored
    HILOtype = HILO_MULT; A = 32'd6; B = 32'd7;
    #1;
    check("rq_mult_start", {31'd0, Start}, 32'd1);
    step();
    HILOtype = HILO_NONE;
    check("rq_mult_busy_c1", {31'd0, Busy}, 32'd1);
    step();
    Req = 1'b1;
    check("rq_mult_busy_c2", {31'd0, Busy}, 32'd1);
    step();
    Req = 1'b0;
    HILOtype = HILO_MTLO; A = 32'd9;
    #1;
    check("rq_mtlo_start", {31'd0, Start}, 32'd0);
    step();
    HILOtype = HILO_NONE;
    check("rq_mtlo_lo", LO, 32'd3);
    step();
    check("rq_mult_busy_c5", {31'd0, Busy}, 32'd1);
    step();
    check("rq_mult_busy_fall", {31'd0, Busy}, 32'd0);
    check("rq_mult_hi", HI, 32'd0);
    check("rq_mult_lo", LO, 32'd42);

    // 5. Divide by zero leaves HI/LO alone
    HILOtype = HILO_MTHI; A = 32'h11;
    step();
    HILOtype = HILO_MTLO; A = 32'h22;
    step();
    check("mthi_hi", HI, 32'h11);
    check("mtlo_lo", LO, 32'h22);
    run_op("divz", HILO_DIV, 32'd100, 32'd0, 10, 32'h11, 32'h22);
    check("divz_hi", HI, 32'h11);
    check("divz_lo", LO, 32'h22);
    HILOtype = HILO_MFLO;
    #1;
    check("mflo_result", MDU_Result, 32'h22);
    HILOtype = HILO_MFHI;
    #1;
    check("mfhi_result", MDU_Result, 32'h11);
    HILOtype = HILO_NONE;
    #1;
    check("none_result", MDU_Result, 32'd0);
    step();

    // 6. DIVU interrupted by async reset, then MULT 2*3
    HILOtype = HILO_DIVU; A = 32'd100; B = 32'd7;
    step();
    HILOtype = HILO_NONE;
    for (int i = 1; i <= 3; i++) step();
    check("rstmid_busy_c4", {31'd0, Busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, Busy}, 32'd0);
    check("rstmid_hi", HI, 32'd0);
    check("rstmid_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    HILOtype = HILO_MULT; A = 32'd2; B = 32'd3;
    #1;
    check("post_mult_start", {31'd0, Start}, 32'd1);
    step();
    HILOtype = HILO_NONE;
    for (int i = 1; i <= 4; i++) step();
    // Last Busy cycle: a new op must be refused, then accepted the next cycle.
    HILOtype = HILO_MULTU; A = 32'd3; B = 32'd3;
    #1;
    check("edge_busy_c5", {31'd0, Busy}, 32'd1);
    check("edge_start_blocked", {31'd0, Start}, 32'd0);
    step();
    check("post_mult_lo", LO, 32'd6);
    check("post_mult_hi", HI, 32'd0);
    check("edge_start_next", {31'd0, Start}, 32'd1);
    step();
    HILOtype = HILO_NONE;
    for (int i = 1; i <= 5; i++) step();
    check("edge_multu_busy_fall", {31'd0, Busy}, 32'd0);
    check("edge_multu_lo", LO, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
